result_serializer: RTL

RESULT_SERIALIZER -- requirements
Module: result_serializer

---
 rtl/zynet_pkg.sv | 19 +
 rtl/result_serializer_argmax_tracker.sv | 67 ++++++
 rtl/result_serializer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/zynet_pkg.sv
// Shared definitions for the network result path.
// Holds the serializer FSM state type, default word/vector sizes and the
// index-width helper used to size word-index ports.
package zynet_pkg;

  localparam int unsigned DEF_WORD_SIZE   = 16;
  localparam int unsigned DEF_OUTPUT_SIZE = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  // Width of an index selecting one of n words (never narrower than 1 bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_serializer_argmax_tracker.sv
// argmax_tracker: running signed maximum over the words of one vector as
// they are transferred; publishes the index of the maximum on the final
// transfer. Ties keep the lower index (strict greater-than update).
// The whole module only exists when RESULT_ARGMAX_EN is defined, so the
// default build carries no comparator at all.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   start_i          : vector capture edge; restarts tracking, drops class_valid_o
//   xfer_i           : a word is transferred this cycle
//   last_i           : the transferred word is the final one of the vector
//   word_i, index_i  : the word currently presented and its index
//   class_o          : index of the maximum of the last completed vector
//   class_valid_o    : class_o is valid
`ifdef RESULT_ARGMAX_EN
module argmax_tracker
  import zynet_pkg::*;
#(
  parameter int WORD_SIZE   = DEF_WORD_SIZE,
  parameter int OUTPUT_SIZE = DEF_OUTPUT_SIZE,
  localparam int IW         = idx_width(OUTPUT_SIZE)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 start_i,
  input  logic                 xfer_i,
  input  logic                 last_i,
  input  logic [WORD_SIZE-1:0] word_i,
  input  logic [IW-1:0]        index_i,
  output logic [IW-1:0]        class_o,
  output logic                 class_valid_o
);

  logic signed [WORD_SIZE-1:0] r_max;
  logic [IW-1:0]               r_max_idx;
  logic                        r_seen;
  logic                        w_take;
  logic [IW-1:0]               w_best_idx;

  // The first word of a vector always seeds the maximum.
  assign w_take     = xfer_i && (!r_seen || ($signed(word_i) > r_max));
  assign w_best_idx = w_take ? index_i : r_max_idx;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_max         <= '0;
      r_max_idx     <= '0;
      r_seen        <= 1'b0;
      class_o       <= '0;
      class_valid_o <= 1'b0;
    end else if (start_i) begin
      r_seen        <= 1'b0;
      class_valid_o <= 1'b0;
    end else if (xfer_i) begin
      r_seen <= 1'b1;
      if (w_take) begin
        r_max     <= $signed(word_i);
        r_max_idx <= index_i;
      end
      if (last_i) begin
        class_o       <= w_best_idx;
        class_valid_o <= 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/result_serializer.sv
// result_serializer: captures one network output vector (OUTPUT_SIZE signed
// words of WORD_SIZE bits) and streams it word by word over a valid/ready
// interface, index 0 first.
// Build option: define RESULT_ARGMAX_EN to add argmax tracking (class_o /
// class_valid_o); otherwise both are tied to 0.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   valid_i, data_i  : incoming vector; word k at bits [(k+1)*W-1 : k*W]
//   yumi_o           : vector consumed this cycle (valid_i while idle)
//   valid_o, ready_i : serial word handshake
//   data_o, index_o  : serial word and its index
//   last_o           : data_o carries word OUTPUT_SIZE-1
//   class_o          : argmax index of the last completed vector
//   class_valid_o    : class_o is valid
module result_serializer
  import zynet_pkg::*;
#(
  parameter int WORD_SIZE   = DEF_WORD_SIZE,
  parameter int OUTPUT_SIZE = DEF_OUTPUT_SIZE,
  localparam int IW         = idx_width(OUTPUT_SIZE)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             valid_i,
  input  logic [OUTPUT_SIZE*WORD_SIZE-1:0] data_i,
  output logic                             yumi_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [WORD_SIZE-1:0]             data_o,
  output logic [IW-1:0]                    index_o,
  output logic                             last_o,
  output logic [IW-1:0]                    class_o,
  output logic                             class_valid_o
);

  localparam logic [IW-1:0] LAST_IDX = IW'(OUTPUT_SIZE - 1);

  ser_state_t           r_state;
  ser_state_t           w_state_nxt;
  logic [WORD_SIZE-1:0] r_buf [OUTPUT_SIZE];
  logic [IW-1:0]        r_index;
  logic                 w_capture;
  logic                 w_xfer;

  assign w_capture = (r_state == ST_IDLE) && valid_i;
  assign w_xfer    = valid_o && ready_i;

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (valid_i)           w_state_nxt = ST_SEND;
      ST_SEND: if (w_xfer && last_o)  w_state_nxt = ST_IDLE;
      default:                        w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    yumi_o  = 1'b0;
    valid_o = 1'b0;
    last_o  = 1'b0;
    case (r_state)
      ST_IDLE: yumi_o = valid_i;
      ST_SEND: begin
        valid_o = 1'b1;
        last_o  = (r_index == LAST_IDX);
      end
      default: ;
    endcase
  end

  assign data_o  = r_buf[r_index];
  assign index_o = r_index;

  // Vector buffer and word index
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_index <= '0;
      for (int unsigned k = 0; k < OUTPUT_SIZE; k++) begin
        r_buf[k] <= '0;
      end
    end else if (w_capture) begin
      r_index <= '0;
      for (int unsigned k = 0; k < OUTPUT_SIZE; k++) begin
        r_buf[k] <= data_i[k*WORD_SIZE +: WORD_SIZE];
      end
    end else if (w_xfer && !last_o) begin
      r_index <= r_index + 1'b1;
    end
  end

`ifdef RESULT_ARGMAX_EN
  argmax_tracker #(
    .WORD_SIZE   (WORD_SIZE),
    .OUTPUT_SIZE (OUTPUT_SIZE)
  ) u_argmax (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .start_i       (w_capture),
    .xfer_i        (w_xfer),
    .last_i        (last_o),
    .word_i        (data_o),
    .index_i       (r_index),
    .class_o       (class_o),
    .class_valid_o (class_valid_o)
  );
`else
  assign class_o       = '0;
  assign class_valid_o = 1'b0;
`endif

endmodule
